// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared types and FIFO entry layout for the SPI receive slave
// Entry layout, LSB first: data[WORD_BITS], ch[CH_W], sof, eof, frag
package spi_rx_pkg;
   typedef enum logic {S_IDLE, S_RX} state_t;
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int off_ch(input int wb);
      return wb;
   endfunction
   function automatic int off_sof(input int wb, input int cw);
      return wb + cw;
   endfunction
   function automatic int off_eof(input int wb, input int cw);
      return wb + cw + 1;
   endfunction
   function automatic int off_frag(input int wb, input int cw);
      return wb + cw + 2;
   endfunction
   function automatic int entry_w(input int wb, input int cw);
      return wb + cw + 3;
   endfunction
endpackage

// File: rtl/spi_rx_slave_mc_if.sv
// spi_rx_slave_mc_if: received-word stream plus overrun status/clear
// master drives valid/data/tags/overrun, slave drives out_ready and ovr_clr
interface spi_rx_slave_mc_if #(
   parameter int WORD_BITS = 24,
   parameter int CH_W = 1
);
   logic                 out_valid;
   logic                 out_ready;
   logic [WORD_BITS-1:0] out_data;
   logic [CH_W-1:0]      out_ch;
   logic                 out_sof;
   logic                 out_eof;
   logic                 out_frag;
   logic                 overrun;
   logic                 ovr_clr;
   modport master (
      output out_valid, out_data, out_ch, out_sof, out_eof, out_frag, overrun,
      input  out_ready, ovr_clr
   );
   modport slave (
      input  out_valid, out_data, out_ch, out_sof, out_eof, out_frag, overrun,
      output out_ready, ovr_clr
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push while full is taken only if a pop happens too
// Ports: clk/rst, i_push/i_data write side, i_pop/o_data read side, o_empty/o_full flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [AW:0]      r_cnt;
   logic             w_pop, w_push;
   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   // Empty head reads as zero so the stream fields are 0 when nothing is valid
   assign o_data  = o_empty ? '0 : r_mem[r_rd];
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         r_wr  <= r_wr + AW'(w_push);
         r_rd  <= r_rd + AW'(w_pop);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
endmodule

// File: rtl/spi_rx_slave_mc.sv
// spi_rx_slave_mc: multi-channel SPI mode-0 receive-only slave, words tagged with channel/frame position
// Ports: CLOCK_50/reset, asynchronous sck/mosi/ssel_n pins, bus = output stream with overrun flag/clear
module spi_rx_slave_mc
   import spi_rx_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int WORD_BITS = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              sck,
   input  logic              mosi,
   input  logic [NUM_CH-1:0] ssel_n,
   spi_rx_slave_mc_if.master bus
);
   localparam int CH_W   = ch_w(NUM_CH);
   localparam int CNT_W  = $clog2(WORD_BITS + 1);
   localparam int EW     = entry_w(WORD_BITS, CH_W);
   localparam int O_CH   = off_ch(WORD_BITS);
   localparam int O_SOF  = off_sof(WORD_BITS, CH_W);
   localparam int O_EOF  = off_eof(WORD_BITS, CH_W);
   localparam int O_FRAG = off_frag(WORD_BITS, CH_W);
   logic [2:0]              r_sck_s;
   logic [1:0]              r_mosi_s;
   logic [2:0][NUM_CH-1:0]  r_ss_s;
   logic [1:0]              r_rdy;
   logic [NUM_CH-1:0]       r_armed, w_fall, w_rise;
   state_t                  r_state, w_state_n;
   logic [CH_W-1:0]         r_ch, w_ch_n, w_sel;
   logic [CNT_W-1:0]        r_cnt, w_cnt_n;
   logic [WORD_BITS-1:0]    r_shift, w_shift_n;
   logic                    r_first, w_first_n, r_eof_pend, w_eof_pend_n;
   logic                    r_push, w_push, r_ovr;
   logic                    w_sck_rise, w_desel, w_full, w_empty, w_pop;
   logic [EW-1:0]           r_entry, w_entry, w_head;
   assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
   assign w_fall     = ~r_ss_s[1] & r_ss_s[2] & r_armed;
   assign w_rise     = r_ss_s[1] & ~r_ss_s[2];
   assign w_desel    = w_rise[r_ch];
   assign w_pop      = ~w_empty & bus.out_ready;
   always_comb begin
      w_sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) if (w_fall[i]) w_sel = CH_W'(i);
   end
   always_comb begin
      w_state_n    = r_state;
      w_ch_n       = r_ch;
      w_cnt_n      = r_cnt;
      w_shift_n    = r_shift;
      w_first_n    = r_first;
      w_eof_pend_n = 1'b0;
      w_push       = 1'b0;
      w_entry      = '0;
      // Deferred EOF only ever lands in the first IDLE cycle, where no word can complete
      if (r_eof_pend) begin
         w_push               = 1'b1;
         w_entry[O_CH+:CH_W]  = r_ch;
         w_entry[O_EOF]       = 1'b1;
      end
      if (r_state == S_IDLE) begin
         if (|w_fall) begin
            w_state_n = S_RX;
            w_ch_n    = w_sel;
            w_cnt_n   = '0;
            w_first_n = 1'b1;
         end
      end else begin
         if (w_sck_rise) begin
            w_shift_n = {r_shift[WORD_BITS-2:0], r_mosi_s[1]};
            w_cnt_n   = r_cnt + CNT_W'(1);
            if (w_cnt_n == CNT_W'(WORD_BITS)) begin
               w_push                     = 1'b1;
               w_entry[WORD_BITS-1:0]     = w_shift_n;
               w_entry[O_CH+:CH_W]        = r_ch;
               w_entry[O_SOF]             = r_first;
               w_cnt_n                    = '0;
               w_first_n                  = 1'b0;
            end
         end
         if (w_desel) begin
            w_state_n = S_IDLE;
            if (w_push) w_eof_pend_n = 1'b1;
            else begin
               w_push               = 1'b1;
               w_entry[O_CH+:CH_W]  = r_ch;
               w_entry[O_EOF]       = 1'b1;
               w_entry[O_FRAG]      = w_cnt_n != '0;
            end
         end
      end
   end
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_sck_s    <= '0;
         r_mosi_s   <= '0;
         r_ss_s     <= '1;
         r_rdy      <= '0;
         r_armed    <= '0;
         r_state    <= S_IDLE;
         r_ch       <= '0;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_first    <= 1'b0;
         r_eof_pend <= 1'b0;
         r_push     <= 1'b0;
         r_entry    <= '0;
         r_ovr      <= 1'b0;
      end else begin
         r_sck_s    <= {r_sck_s[1:0], sck};
         r_mosi_s   <= {r_mosi_s[0], mosi};
         r_ss_s     <= {r_ss_s[1:0], ssel_n};
         // Arming waits until the synchroniser holds a real pin sample, not its reset value
         r_rdy      <= {r_rdy[0], 1'b1};
         r_armed    <= r_armed | ({NUM_CH{r_rdy[1]}} & r_ss_s[1]);
         r_state    <= w_state_n;
         r_ch       <= w_ch_n;
         r_cnt      <= w_cnt_n;
         r_shift    <= w_shift_n;
         r_first    <= w_first_n;
         r_eof_pend <= w_eof_pend_n;
         r_push     <= w_push;
         r_entry    <= w_entry;
         r_ovr      <= (r_push & w_full & ~w_pop) | (r_ovr & ~bus.ovr_clr);
      end
   end
   sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (CLOCK_50),
      .rst     (reset),
      .i_push  (r_push),
      .i_data  (r_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );
   assign bus.out_valid = ~w_empty;
   assign bus.out_data  = w_head[WORD_BITS-1:0];
   assign bus.out_ch    = w_head[O_CH+:CH_W];
   assign bus.out_sof   = w_head[O_SOF];
   assign bus.out_eof   = w_head[O_EOF];
   assign bus.out_frag  = w_head[O_FRAG];
   assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_spi_rx_slave_mc.sv
// tb_spi_rx_slave_mc: directed table-driven bench for spi_rx_slave_mc (NUM_CH=2, WORD_BITS=24, FIFO_DEPTH=4)
module tb_spi_rx_slave_mc;
   typedef struct packed {
      logic [23:0] data;
      logic        ch;
      logic        sof;
      logic        eof;
      logic        frag;
   } ent_t;
   typedef struct {
      logic [1:0]  sel;
      int          nbits;
      logic [47:0] bits;
      int          hp;
      int          e0;
      int          ne;
   } vec_t;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sck = 1'b0;
   logic       mosi = 1'b0;
   logic [1:0] ssel_n = 2'b11;
   ent_t       q[$];
   ent_t       exp_e[17];
   vec_t       vecs[5];
   int         n_run = 0;
   int         n_fail = 0;
   always #5 clk = ~clk;
   spi_rx_slave_mc_if #(.WORD_BITS(24), .CH_W(1)) bus();
   spi_rx_slave_mc #(.NUM_CH(2), .WORD_BITS(24), .FIFO_DEPTH(4)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .sck      (sck),
      .mosi     (mosi),
      .ssel_n   (ssel_n),
      .bus      (bus)
   );
   always @(negedge clk)
      if (!reset && bus.out_valid && bus.out_ready)
         q.push_back({bus.out_data, bus.out_ch, bus.out_sof, bus.out_eof, bus.out_frag});
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_run++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send_bits(input logic [47:0] b, input int n, input int hp);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = b[i];
         tick(hp);
         sck = 1'b1;
         tick(hp);
         sck = 1'b0;
      end
   endtask
   task automatic frame(input logic [1:0] sel, input logic [47:0] b, input int n, input int hp);
      ssel_n = sel;
      tick(hp);
      send_bits(b, n, hp);
      tick(hp);
      ssel_n = 2'b11;
      tick(20);
   endtask
   task automatic chk_q(input string name, input int e0, input int ne);
      chk({name, " count"}, q.size(), ne);
      for (int i = 0; i < ne && i < q.size(); i++)
         chk($sformatf("%s entry%0d", name, i), q[i], exp_e[e0+i]);
      q.delete();
   endtask
   function automatic logic [31:0] head();
      return {bus.out_valid, bus.out_data, bus.out_ch, bus.out_sof, bus.out_eof, bus.out_frag, bus.overrun};
   endfunction
   initial begin
      //          data        ch    sof   eof   frag
      exp_e[0]  = {24'hAA5500, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_e[1]  = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_e[2]  = {24'h0055AA, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_e[3]  = {24'h123456, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_e[4]  = {24'h000000, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_e[5]  = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_e[6]  = {24'hC3A5F0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_e[7]  = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_e[8]  = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_e[9]  = {24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_e[10] = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_e[11] = {24'h111111, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_e[12] = {24'h222222, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_e[13] = {24'h333333, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_e[14] = {24'h444444, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_e[15] = {24'h5A5A5A, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_e[16] = {24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
      //          ssel_n  nbits  bits                hp   e0  ne
      vecs[0] = '{2'b10, 24, 48'h000000AA5500, 100, 0, 2};
      vecs[1] = '{2'b01, 48, 48'h0055AA123456, 8,   2, 3};
      vecs[2] = '{2'b10, 16, 48'h00000000AA55, 8,   5, 1};
      vecs[3] = '{2'b00, 24, 48'h000000C3A5F0, 8,   6, 2};
      vecs[4] = '{2'b10, 0,  48'h000000000000, 8,   8, 1};
      bus.out_ready = 1'b1;
      bus.ovr_clr = 1'b0;
      tick(4);
      chk("reset outputs", head(), 32'h0);
      reset = 1'b0;
      tick(5);
      for (int v = 0; v < 5; v++) begin
         frame(vecs[v].sel, vecs[v].bits, vecs[v].nbits, vecs[v].hp);
         chk_q($sformatf("vec%0d", v), vecs[v].e0, vecs[v].ne);
      end
      // Latency: final SCK rise sampled at edge k appears as out_valid after edge k+3
      bus.out_ready = 1'b0;
      ssel_n = 2'b10;
      tick(8);
      send_bits(48'hABCDEF >> 1, 23, 8);
      mosi = 1'b1;
      tick(8);
      sck = 1'b1;
      tick(3);
      chk("latency k+2 valid", bus.out_valid, 1'b0);
      tick(1);
      chk("latency k+3 valid", bus.out_valid, 1'b1);
      chk("latency head", {bus.out_data, bus.out_ch, bus.out_sof, bus.out_eof, bus.out_frag}, exp_e[9]);
      tick(8);
      sck = 1'b0;
      tick(8);
      ssel_n = 2'b11;
      tick(20);
      bus.out_ready = 1'b1;
      tick(5);
      chk_q("latency", 9, 2);
      // Overrun: five words into a four-deep FIFO with no consumer
      bus.out_ready = 1'b0;
      ssel_n = 2'b10;
      tick(8);
      for (int w = 1; w <= 5; w++) send_bits(48'(24'(w) * 24'h111111), 24, 8);
      tick(8);
      ssel_n = 2'b11;
      tick(20);
      chk("overrun set", bus.overrun, 1'b1);
      chk("overrun head", {bus.out_valid, bus.out_data}, {1'b1, 24'h111111});
      bus.ovr_clr = 1'b1;
      tick(1);
      bus.ovr_clr = 1'b0;
      chk("overrun cleared", bus.overrun, 1'b0);
      bus.out_ready = 1'b1;
      tick(10);
      chk_q("overrun drain", 11, 4);
      chk("drained valid", bus.out_valid, 1'b0);
      // Reset mid-frame with the select held low: channel must rearm
      ssel_n = 2'b10;
      tick(8);
      send_bits(48'hABC, 12, 8);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(5);
      send_bits(48'hFFFFFF, 24, 8);
      tick(8);
      ssel_n = 2'b11;
      tick(20);
      chk_q("mid-frame reset", 0, 0);
      frame(2'b10, 48'h5A5A5A, 24, 8);
      chk_q("rearm", 15, 2);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
